// File: rtl/prbs8_checker_if.sv
// Serial PRBS receive bus between a stream source and prbs8_checker.
//   bit_in, bit_valid : received bit and its qualifier (source -> checker)
//   locked            : checker synchronised to the stream
//   err_pulse         : one-cycle pulse, previously accepted bit mismatched
//   err_count         : saturating mismatch total since reset
//   bit_count         : bits checked while locked (zero unless counter is built)
interface prbs8_checker_if #(
    parameter int unsigned ERR_W = 16
);
    logic             bit_in;
    logic             bit_valid;
    logic             locked;
    logic             err_pulse;
    logic [ERR_W-1:0] err_count;
    logic [31:0]      bit_count;

    modport master (
        output bit_in,
        output bit_valid,
        input  locked,
        input  err_pulse,
        input  err_count,
        input  bit_count
    );

    modport slave (
        input  bit_in,
        input  bit_valid,
        output locked,
        output err_pulse,
        output err_count,
        output bit_count
    );
endinterface

// File: rtl/prbs8_checker.sv
// Self-synchronising checker for the 8-bit PRBS (taps 7,5,4,3, shift left).
// Seeds its register from 8 received bits, then predicts each bit, flags and
// counts mismatches, and drops lock when one window holds ERR_THRESH errors.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : prbs8_checker_if.slave (bit_in/bit_valid in; locked, err_pulse,
//          err_count, bit_count out, all registered)
// Optional feature macro: PRBS8_CHK_BITCNT_EN builds the locked-bit counter;
// without it bit_count is tied to zero.
module prbs8_checker #(
    parameter int unsigned WINDOW     = 64,
    parameter int unsigned ERR_THRESH = 4,
    parameter int unsigned ERR_W      = 16
) (
    input  logic           clk,
    input  logic           rst,
    prbs8_checker_if.slave bus
);
    localparam int unsigned WIN_W  = $clog2(WINDOW);
    localparam int unsigned ERRC_W = $clog2(ERR_THRESH + 1);

    typedef enum logic {SEED, LOCK} state_t;

    state_t             state_q, state_d;
    logic [7:0]         s_q, s_d;
    logic [2:0]         seed_cnt_q, seed_cnt_d;
    logic [WIN_W-1:0]   win_cnt_q, win_cnt_d;
    logic [ERRC_W-1:0]  win_err_q, win_err_d;
    logic               locked_q, locked_d;
    logic               err_pulse_q, err_pulse_d;
    logic [ERR_W-1:0]   err_count_q, err_count_d;
`ifdef PRBS8_CHK_BITCNT_EN
    logic [31:0]        bit_count_q, bit_count_d;
`endif

    logic               expect_c;
    logic               mismatch_c;
    logic [ERRC_W-1:0]  win_err_nx_c;

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= SEED;
            s_q         <= '0;
            seed_cnt_q  <= '0;
            win_cnt_q   <= '0;
            win_err_q   <= '0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            err_count_q <= '0;
`ifdef PRBS8_CHK_BITCNT_EN
            bit_count_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            seed_cnt_q  <= seed_cnt_d;
            win_cnt_q   <= win_cnt_d;
            win_err_q   <= win_err_d;
            locked_q    <= locked_d;
            err_pulse_q <= err_pulse_d;
            err_count_q <= err_count_d;
`ifdef PRBS8_CHK_BITCNT_EN
            bit_count_q <= bit_count_d;
`endif
        end
    end

    // Next-state: seeding, prediction, error accounting and lock-loss window
    always_comb begin
        state_d     = state_q;
        s_d         = s_q;
        seed_cnt_d  = seed_cnt_q;
        win_cnt_d   = win_cnt_q;
        win_err_d   = win_err_q;
        locked_d    = locked_q;
        err_pulse_d = 1'b0;
        err_count_d = err_count_q;
`ifdef PRBS8_CHK_BITCNT_EN
        bit_count_d = bit_count_q;
`endif
        expect_c     = s_q[7] ^ s_q[5] ^ s_q[4] ^ s_q[3];
        mismatch_c   = bus.bit_in ^ expect_c;
        // win_err_q stays below ERR_THRESH, so this sum cannot overflow
        win_err_nx_c = win_err_q + ERRC_W'(mismatch_c);

        if (bus.bit_valid) begin
            case (state_q)
                SEED: begin
                    s_d = {s_q[6:0], bus.bit_in};
                    if (seed_cnt_q == 3'd7) begin
                        seed_cnt_d = '0;
                        // An all-zero seed is the LFSR lock-up state: keep seeding
                        if (s_d != 8'd0) begin
                            state_d   = LOCK;
                            locked_d  = 1'b1;
                            win_cnt_d = '0;
                            win_err_d = '0;
                        end
                    end else begin
                        seed_cnt_d = seed_cnt_q + 3'd1;
                    end
                end
                LOCK: begin
                    // Shift in the prediction so a corrupt bit never propagates
                    s_d         = {s_q[6:0], expect_c};
                    err_pulse_d = mismatch_c;
                    if (mismatch_c && (err_count_q != {ERR_W{1'b1}})) begin
                        err_count_d = err_count_q + ERR_W'(1);
                    end
`ifdef PRBS8_CHK_BITCNT_EN
                    bit_count_d = bit_count_q + 32'd1;
`endif
                    // Threshold wins over the window wrap on the same bit
                    if (win_err_nx_c == ERRC_W'(ERR_THRESH)) begin
                        state_d    = SEED;
                        locked_d   = 1'b0;
                        seed_cnt_d = '0;
                        s_d        = '0;
                        win_cnt_d  = '0;
                        win_err_d  = '0;
                    end else if (win_cnt_q == WIN_W'(WINDOW - 1)) begin
                        win_cnt_d = '0;
                        win_err_d = '0;
                    end else begin
                        win_cnt_d = win_cnt_q + WIN_W'(1);
                        win_err_d = win_err_nx_c;
                    end
                end
                default: state_d = SEED;
            endcase
        end
    end

    assign bus.locked    = locked_q;
    assign bus.err_pulse = err_pulse_q;
    assign bus.err_count = err_count_q;
`ifdef PRBS8_CHK_BITCNT_EN
    assign bus.bit_count = bit_count_q;
`else
    assign bus.bit_count = 32'd0;
`endif
endmodule

// File: tb/tb_prbs8_checker.sv
// Directed bench for prbs8_checker: clean lock, single error, lock loss,
// window wrap boundary, zero-seed lock-up, valid gaps and mid-lock reset.
module tb_prbs8_checker;
    logic clk;
    logic rst;
    int   checks;
    int   errors;
    logic [7:0] g;

`ifdef PRBS8_CHK_BITCNT_EN
    localparam bit BC_EN = 1'b1;
`else
    localparam bit BC_EN = 1'b0;
`endif

    prbs8_checker_if #(.ERR_W(16)) bif ();

    prbs8_checker #(.WINDOW(64), .ERR_THRESH(4), .ERR_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference generator: returns the feedback bit and advances the state
    task automatic gen_bit(output logic b);
        b = g[7] ^ g[5] ^ g[4] ^ g[3];
        g = {g[6:0], b};
    endtask

    // Apply one edge; outputs are sampled 1 ns after the rising edge
    task automatic drive(input logic b, input logic v);
        @(negedge clk);
        bif.bit_in    = b;
        bif.bit_valid = v;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst           = 1'b1;
        bif.bit_valid = 1'b0;
        bif.bit_in    = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (bif.locked !== 1'b0) begin errors++; $display("FAIL reset_locked got %0b exp 0", bif.locked); end
        checks++;
        if (bif.err_pulse !== 1'b0) begin errors++; $display("FAIL reset_err_pulse got %0b exp 0", bif.err_pulse); end
        checks++;
        if (bif.err_count !== 16'd0) begin errors++; $display("FAIL reset_err_count got %0d exp 0", bif.err_count); end
        checks++;
        if (bif.bit_count !== 32'd0) begin errors++; $display("FAIL reset_bit_count got %0d exp 0", bif.bit_count); end
    endtask

    task automatic test_clean_stream();
        logic b;
        int   pulses;
        do_reset();
        g = 8'hA5;
        pulses = 0;
        for (int i = 0; i < 200; i++) begin
            gen_bit(b);
            drive(b, 1'b1);
            if (bif.err_pulse === 1'b1) pulses++;
            if (i == 6) begin
                checks++;
                if (bif.locked !== 1'b0) begin errors++; $display("FAIL clean_unlocked_at_7 got %0b exp 0", bif.locked); end
            end
            if (i == 7) begin
                checks++;
                if (bif.locked !== 1'b1) begin errors++; $display("FAIL clean_locked_at_8 got %0b exp 1", bif.locked); end
            end
        end
        checks++;
        if (pulses != 0) begin errors++; $display("FAIL clean_pulses got %0d exp 0", pulses); end
        checks++;
        if (bif.err_count !== 16'd0) begin errors++; $display("FAIL clean_err_count got %0d exp 0", bif.err_count); end
        checks++;
        if (bif.bit_count !== (BC_EN ? 32'd192 : 32'd0)) begin errors++; $display("FAIL clean_bit_count got %0d exp %0d", bif.bit_count, BC_EN ? 192 : 0); end
        checks++;
        if (bif.locked !== 1'b1) begin errors++; $display("FAIL clean_locked_end got %0b exp 1", bif.locked); end
    endtask

    task automatic test_single_error();
        logic b;
        int   pulses;
        do_reset();
        g = 8'hA5;
        pulses = 0;
        for (int i = 0; i < 100; i++) begin
            gen_bit(b);
            if (i == 40) begin
                drive(~b, 1'b1);
                checks++;
                if (bif.err_pulse !== 1'b1) begin errors++; $display("FAIL single_pulse got %0b exp 1", bif.err_pulse); end
                // An idle edge right after must clear the pulse
                drive(1'($urandom_range(0, 1)), 1'b0);
                checks++;
                if (bif.err_pulse !== 1'b0) begin errors++; $display("FAIL single_idle_clears got %0b exp 0", bif.err_pulse); end
            end else begin
                drive(b, 1'b1);
                if (bif.err_pulse === 1'b1) pulses++;
            end
        end
        checks++;
        if (pulses != 0) begin errors++; $display("FAIL single_extra_pulses got %0d exp 0", pulses); end
        checks++;
        if (bif.err_count !== 16'd1) begin errors++; $display("FAIL single_err_count got %0d exp 1", bif.err_count); end
        checks++;
        if (bif.locked !== 1'b1) begin errors++; $display("FAIL single_locked got %0b exp 1", bif.locked); end
        checks++;
        if (bif.bit_count !== (BC_EN ? 32'd92 : 32'd0)) begin errors++; $display("FAIL single_bit_count got %0d exp %0d", bif.bit_count, BC_EN ? 92 : 0); end
    endtask

    task automatic test_lock_loss();
        logic b;
        int   pulses;
        do_reset();
        g = 8'hA5;
        for (int i = 0; i < 27; i++) begin
            gen_bit(b);
            if (i == 20 || i == 22 || i == 24 || i == 26) b = ~b;
            drive(b, 1'b1);
            if (i == 24) begin
                checks++;
                if (bif.locked !== 1'b1) begin errors++; $display("FAIL loss_locked_after_3 got %0b exp 1", bif.locked); end
            end
        end
        checks++;
        if (bif.locked !== 1'b0) begin errors++; $display("FAIL loss_unlocked got %0b exp 0", bif.locked); end
        checks++;
        if (bif.err_pulse !== 1'b1) begin errors++; $display("FAIL loss_pulse got %0b exp 1", bif.err_pulse); end
        checks++;
        if (bif.err_count !== 16'd4) begin errors++; $display("FAIL loss_err_count got %0d exp 4", bif.err_count); end
        for (int i = 0; i < 8; i++) begin
            gen_bit(b);
            drive(b, 1'b1);
            if (i == 6) begin
                checks++;
                if (bif.locked !== 1'b0) begin errors++; $display("FAIL resync_early got %0b exp 0", bif.locked); end
            end
        end
        checks++;
        if (bif.locked !== 1'b1) begin errors++; $display("FAIL resync_locked got %0b exp 1", bif.locked); end
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            gen_bit(b);
            drive(b, 1'b1);
            if (bif.err_pulse === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0 || bif.err_count !== 16'd4) begin errors++; $display("FAIL resync_clean got pulses %0d count %0d exp 0 and 4", pulses, bif.err_count); end
        checks++;
        if (bif.bit_count !== (BC_EN ? 32'd39 : 32'd0)) begin errors++; $display("FAIL loss_bit_count got %0d exp %0d", bif.bit_count, BC_EN ? 39 : 0); end
    endtask

    // Lock at stream bit 7; first window covers stream bits 8..71
    task automatic test_window_wrap();
        logic b;
        do_reset();
        g = 8'hA5;
        for (int i = 0; i < 91; i++) begin
            gen_bit(b);
            if (i == 60 || i == 65 || i == 71 || i == 72 || i == 80 || i == 85 || i == 90) b = ~b;
            drive(b, 1'b1);
            if (i == 72) begin
                checks++;
                if (bif.locked !== 1'b1) begin errors++; $display("FAIL wrap_locked_at_72 got %0b exp 1", bif.locked); end
            end
            if (i == 85) begin
                checks++;
                if (bif.locked !== 1'b1 || bif.err_count !== 16'd6) begin errors++; $display("FAIL wrap_locked_at_85 got locked %0b count %0d exp 1 and 6", bif.locked, bif.err_count); end
            end
        end
        checks++;
        if (bif.locked !== 1'b0 || bif.err_count !== 16'd7) begin errors++; $display("FAIL wrap_unlock_at_90 got locked %0b count %0d exp 0 and 7", bif.locked, bif.err_count); end
    endtask

    task automatic test_zero_seed();
        logic b;
        int   pulses;
        do_reset();
        pulses = 0;
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 1'b1);
            if (bif.err_pulse === 1'b1) pulses++;
            if (i == 7 || i == 15) begin
                checks++;
                if (bif.locked !== 1'b0) begin errors++; $display("FAIL zero_locked at %0d got %0b exp 0", i, bif.locked); end
            end
        end
        g = 8'hA5;
        for (int i = 0; i < 32; i++) begin
            gen_bit(b);
            drive(b, 1'b1);
            if (bif.err_pulse === 1'b1) pulses++;
            if (i == 7) begin
                checks++;
                if (bif.locked !== 1'b1) begin errors++; $display("FAIL zero_then_lock got %0b exp 1", bif.locked); end
            end
        end
        checks++;
        if (pulses != 0 || bif.err_count !== 16'd0) begin errors++; $display("FAIL zero_no_errors got pulses %0d count %0d exp 0 and 0", pulses, bif.err_count); end
    endtask

    task automatic test_valid_gaps();
        logic b;
        int   pulses;
        int   n;
        int   iter;
        do_reset();
        g = 8'hA5;
        pulses = 0;
        n = 0;
        iter = 0;
        while (n < 200 && iter < 2000) begin
            iter++;
            if ($urandom_range(0, 1) == 1) begin
                gen_bit(b);
                drive(b, 1'b1);
                n++;
                if (n == 7) begin
                    checks++;
                    if (bif.locked !== 1'b0) begin errors++; $display("FAIL gaps_unlocked_at_7 got %0b exp 0", bif.locked); end
                end
                if (n == 8) begin
                    checks++;
                    if (bif.locked !== 1'b1) begin errors++; $display("FAIL gaps_locked_at_8 got %0b exp 1", bif.locked); end
                end
            end else begin
                drive(1'($urandom_range(0, 1)), 1'b0);
            end
            if (bif.err_pulse === 1'b1) pulses++;
        end
        checks++;
        if (n != 200) begin errors++; $display("FAIL gaps_budget got %0d valid bits exp 200", n); end
        checks++;
        if (pulses != 0 || bif.err_count !== 16'd0) begin errors++; $display("FAIL gaps_errors got pulses %0d count %0d exp 0 and 0", pulses, bif.err_count); end
        checks++;
        if (bif.bit_count !== (BC_EN ? 32'd192 : 32'd0)) begin errors++; $display("FAIL gaps_bit_count got %0d exp %0d", bif.bit_count, BC_EN ? 192 : 0); end
        // Corrupt one bit so the reset below has state to clear
        gen_bit(b);
        drive(~b, 1'b1);
        checks++;
        if (bif.err_pulse !== 1'b1 || bif.err_count !== 16'd1) begin errors++; $display("FAIL gaps_inject got pulse %0b count %0d exp 1 and 1", bif.err_pulse, bif.err_count); end
        @(negedge clk);
        rst           = 1'b1;
        bif.bit_valid = 1'b1;
        bif.bit_in    = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (bif.locked !== 1'b0 || bif.err_pulse !== 1'b0 || bif.err_count !== 16'd0 || bif.bit_count !== 32'd0) begin
            errors++;
            $display("FAIL midlock_reset got locked %0b pulse %0b count %0d bits %0d exp all 0", bif.locked, bif.err_pulse, bif.err_count, bif.bit_count);
        end
        @(negedge clk);
        rst           = 1'b0;
        bif.bit_valid = 1'b0;
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        g             = 8'hA5;
        rst           = 1'b1;
        bif.bit_in    = 1'b0;
        bif.bit_valid = 1'b0;
        test_reset();
        test_clean_stream();
        test_single_error();
        test_lock_loss();
        test_window_wrap();
        test_zero_seed();
        test_valid_gaps();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
